nios_pio_gpio: RTL and testbench
================================

Name: nios_pio_gpio

Overview:
- Parametrised Avalon-MM slave GPIO port for the NIOS II system; the successor to the single-bit output PIO.
- Provides DATA_WIDTH bidirectional pins with per-bit direction control and a 2-flop input synchronizer.
- Adds edge capture with selectable edge type and a maskable level interrupt to the CPU.
- Zero-wait-state slave; read data is combinational from registered state.

Parameters:
- DATA_WIDTH, 8, pin count; legal range 1..32.
- RESET_VALUE, 0, reset value of the output data register (DATA_WIDTH bits).
- EDGE_TYPE, 0, captured edge: 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- address  input  3  register word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  input  32  write data; only bits [DATA_WIDTH-1:0] are used.
- readdata  output  32  read data, zero-extended above DATA_WIDTH.
- irq  output  1  level interrupt, active high.
- pio_in  input  DATA_WIDTH  asynchronous pin inputs.
- pio_out  output  DATA_WIDTH  output data register.
- pio_oe  output  DATA_WIDTH  per-bit output enable (the direction register).

Behaviour:
- One clock (clk); reset is asynchronous, active-low (reset_n).
- Reset values:
  - data_out = RESET_VALUE; direction = 0 (all inputs); irq_mask = 0; edge_capture = 0.
  - Synchronizer and previous-sample registers = 0; arm counter = 0.
  - Consequently pio_out = RESET_VALUE, pio_oe = 0, irq = 0.
- Register map (word address):
  - 0 DATA: write updates data_out. Read returns, per bit, data_out where direction=1 and sync2 (synchronized pin) where direction=0.
  - 1 DIRECTION: read/write; 1 = output.
  - 2 IRQ_MASK: read/write.
  - 3 EDGE_CAPTURE: read returns edge_capture. Write-1-to-clear per bit; 0 bits are unaffected.
  - 4 OUTSET / 5 OUTCLEAR: see Optional Feature.
  - 6, 7: reads return 0; writes are ignored.
- Reads have no side effects. readdata is valid in the same cycle as address/chipselect (latency 0).
- Write timing: a written value is visible on outputs (pio_out, pio_oe) and to reads from the next clock edge.
- Input path:
  - sync1 <= pio_in; sync2 <= sync1; prev <= sync2.
  - A pin change is visible in DATA two edges later.
- Edge detect:
  - rising = sync2 & ~prev; falling = ~sync2 & prev; any = sync2 ^ prev, selected by EDGE_TYPE.
  - A detected edge sets edge_capture on the next edge, i.e. three edges after the pin change.
  - Edges are detected on all bits regardless of direction.
- Arm counter: a 2-bit saturating counter counts up after reset. Edge detection is gated off until the counter reaches 3. Pins held high through reset therefore produce no spurious capture.
- Simultaneous edge and write-1-to-clear on the same bit in the same cycle: the bit stays set (set wins; no edge is lost).
- irq = |(edge_capture & irq_mask), combinational from registers. It is deasserted the cycle after the last enabled capture bit is cleared or masked.
- Reset asserted mid-operation: all state returns to reset values immediately; any pending captures are lost.

Optional Feature:
- Macro: NIOS_PIO_BITSETCLR_EN.
- Defined:
  - A write to address 4 performs data_out <= data_out | writedata.
  - A write to address 5 performs data_out <= data_out & ~writedata.
  - These allow atomic bit manipulation without read-modify-write. Reads of addresses 4 and 5 return 0.
- Not defined: addresses 4 and 5 behave like 6 and 7 (reads return 0, writes are ignored). No set/clear logic is synthesized.

Test Plan:
- Reset release with pio_in=8'hFF held, EDGE_TYPE=0 -> pio_out=RESET_VALUE, pio_oe=0, edge_capture stays 0 for 10 cycles, DATA reads 8'hFF.
- Write DIRECTION=8'h0F, DATA=8'hA5, pio_in=8'h30 -> pio_oe=8'h0F, pio_out=8'hA5, DATA read after 2 cycles = 8'h35.
- EDGE_TYPE=0, IRQ_MASK=8'h01, pio_in bit0 0->1 -> EDGE_CAPTURE=8'h01 three edges later, irq=1. Write 8'h01 to address 3 -> irq=0 next cycle.
- Rising edge on bit2 in the same cycle as a write of 8'h04 to EDGE_CAPTURE -> bit2 remains 1. Bit2 set but IRQ_MASK bit2=0 -> irq stays 0.
- With NIOS_PIO_BITSETCLR_EN: DATA=8'h0F, write 8'h30 to address 4 -> 8'h3F, write 8'h03 to address 5 -> 8'h3C. Without the macro, both writes leave 8'h0F.
- reset_n pulsed low mid-run with captures pending -> edge_capture=0, irq=0, pio_out=RESET_VALUE immediately.

Source files
------------

// File: rtl/nios_pio_gpio.sv
// nios_pio_gpio: Avalon-MM GPIO slave for the NIOS II system.
// DATA_WIDTH bidirectional pins with per-bit direction, a 2-flop input
// synchronizer, edge capture (rising/falling/any) and a maskable level irq.
// Zero-wait-state; readdata is combinational from registered state.
// Optional feature macro: NIOS_PIO_BITSETCLR_EN enables OUTSET (word 4) and
// OUTCLEAR (word 5) for atomic bit manipulation of the output register.
module nios_pio_gpio #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    EDGE_TYPE   = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  irq,
    input  logic [DATA_WIDTH-1:0] pio_in,
    output logic [DATA_WIDTH-1:0] pio_out,
    output logic [DATA_WIDTH-1:0] pio_oe
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
`ifdef NIOS_PIO_BITSETCLR_EN
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd5;
`endif

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  unused_wdata;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] dir_q, dir_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] cap_q, cap_d;
    logic [DATA_WIDTH-1:0] cap_clr;
    logic [DATA_WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [1:0]            arm_q, arm_d;
    logic                  armed;
    logic [DATA_WIDTH-1:0] edge_raw;
    logic [DATA_WIDTH-1:0] edge_det;
    logic [DATA_WIDTH-1:0] rd_val;

    assign wr_en        = chipselect & ~write_n;
    assign wdata        = writedata[DATA_WIDTH-1:0];
    // Upper write-data bits beyond the pin count are intentionally ignored.
    assign unused_wdata = ^writedata;

    // Register-file write decode: next values for the CPU-writable registers.
    always_comb begin
        data_d  = data_q;
        dir_d   = dir_q;
        mask_d  = mask_q;
        cap_clr = '0;
        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_d  = wdata;
                ADDR_DIR:      dir_d   = wdata;
                ADDR_IRQ_MASK: mask_d  = wdata;
                ADDR_EDGE_CAP: cap_clr = wdata;
`ifdef NIOS_PIO_BITSETCLR_EN
                ADDR_OUTSET:   data_d  = data_q | wdata;
                ADDR_OUTCLR:   data_d  = data_q & ~wdata;
`endif
                default: ;
            endcase
        end
    end

    // Edge select from the synchronized sample and its one-cycle-old copy.
    always_comb begin
        case (EDGE_TYPE)
            1:       edge_raw = ~sync2_q & prev_q;
            2:       edge_raw = sync2_q ^ prev_q;
            default: edge_raw = sync2_q & ~prev_q;
        endcase
    end

    // Edges are ignored until the synchronizer pipeline has filled after
    // reset, so pins held high through reset do not look like rising edges.
    assign armed    = (arm_q == 2'd3);
    assign edge_det = armed ? edge_raw : '0;

    // Capture next state: a new edge wins over a same-cycle write-1-to-clear.
    always_comb begin
        cap_d = (cap_q & ~cap_clr) | edge_det;
        arm_d = armed ? arm_q : arm_q + 2'd1;
    end

    // State registers, all cleared asynchronously by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= RESET_VALUE;
            dir_q   <= '0;
            mask_q  <= '0;
            cap_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            arm_q   <= 2'd0;
        end else begin
            data_q  <= data_d;
            dir_q   <= dir_d;
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            sync1_q <= pio_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            arm_q   <= arm_d;
        end
    end

    // Zero-latency read mux; unmapped words (and 4/5 without set/clear) read 0.
    always_comb begin
        rd_val   = '0;
        readdata = '0;
        case (address)
            ADDR_DATA:     rd_val = (data_q & dir_q) | (sync2_q & ~dir_q);
            ADDR_DIR:      rd_val = dir_q;
            ADDR_IRQ_MASK: rd_val = mask_q;
            ADDR_EDGE_CAP: rd_val = cap_q;
            default:       rd_val = '0;
        endcase
        readdata[DATA_WIDTH-1:0] = rd_val;
    end

    assign irq     = |(cap_q & mask_q);
    assign pio_out = data_q;
    assign pio_oe  = dir_q;

endmodule

// File: tb/tb_nios_pio_gpio.sv
// Testbench for nios_pio_gpio: directed scenarios plus a randomized run
// compared against a pin-history reference model.
module tb_nios_pio_gpio;

    localparam int         DW = 8;
    localparam logic [7:0] RV = 8'h5A;
    localparam int         ET = 0;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [7:0]  pio_in;
    logic [7:0]  pio_out;
    logic [7:0]  pio_oe;

    int checks = 0;
    int errors = 0;

    nios_pio_gpio #(
        .DATA_WIDTH (DW),
        .RESET_VALUE(RV),
        .EDGE_TYPE  (ET)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .pio_in    (pio_in),
        .pio_out   (pio_out),
        .pio_oe    (pio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register values plus the list of pin samples taken at
    // each clock edge since reset. The CPU sees the pin as it was two edges
    // ago; an edge between the samples of edges n-3 and n-2 is captured at
    // edge n, once at least four edges have passed since reset.
    logic [7:0] data_m, dir_m, mask_m, cap_m;
    logic [7:0] hist[$];
    int         n_edges;

    function automatic logic [7:0] smp(input int k);
        if (k < 1 || k > hist.size()) return 8'h00;
        return hist[k-1];
    endfunction

    function automatic logic [7:0] pin_seen();
        return smp(hist.size() - 1);
    endfunction

    function automatic logic [31:0] exp_read(input logic [2:0] a);
        case (a)
            3'd0:    return {24'h0, (data_m & dir_m) | (pin_seen() & ~dir_m)};
            3'd1:    return {24'h0, dir_m};
            3'd2:    return {24'h0, mask_m};
            3'd3:    return {24'h0, cap_m};
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                data_m  = RV;
                dir_m   = 8'h00;
                mask_m  = 8'h00;
                cap_m   = 8'h00;
                n_edges = 0;
                hist.delete();
            end else begin
                logic [7:0] nw, od, ev, clr, wd;
                n_edges++;
                nw = smp(n_edges - 2);
                od = smp(n_edges - 3);
                case (ET)
                    1:       ev = ~nw & od;
                    2:       ev = nw ^ od;
                    default: ev = nw & ~od;
                endcase
                if (n_edges < 4) ev = 8'h00;
                clr = 8'h00;
                wd  = writedata[7:0];
                if (chipselect && !write_n) begin
                    case (address)
                        3'd0: data_m = wd;
                        3'd1: dir_m  = wd;
                        3'd2: mask_m = wd;
                        3'd3: clr    = wd;
`ifdef NIOS_PIO_BITSETCLR_EN
                        3'd4: data_m = data_m | wd;
                        3'd5: data_m = data_m & ~wd;
`endif
                        default: ;
                    endcase
                end
                cap_m = (cap_m & ~clr) | ev;
                hist.push_back(pio_in);
            end
        end
    end

    // Bus tasks are entered between a falling and the next rising edge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n    = 1'b0;
        pio_in     = 8'hFF;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'h0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus_read(3'd3, rd);
            checks++;
            if (rd !== 32'h0 || pio_out !== RV || pio_oe !== 8'h00 || irq !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d cap=%h out=%h oe=%h irq=%b want cap=0 out=%h oe=0 irq=0",
                         i, rd, pio_out, pio_oe, irq, RV);
            end
            @(negedge clk);
        end
        bus_read(3'd0, rd);
        checks++;
        if (rd !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL reset_data_read got=%h want=000000ff", rd);
        end
    endtask

    task automatic test_dir_data();
        logic [31:0] rd;
        pio_in = 8'h30;
        bus_write(3'd1, 32'h0F);
        bus_write(3'd0, 32'hA5);
        checks++;
        if (pio_oe !== 8'h0F || pio_out !== 8'hA5) begin
            errors++;
            $display("FAIL dir_data_outputs oe=%h out=%h want oe=0f out=a5", pio_oe, pio_out);
        end
        repeat (2) @(negedge clk);
        bus_read(3'd0, rd);
        checks++;
        if (rd !== 32'h35) begin
            errors++;
            $display("FAIL dir_data_read got=%h want=00000035", rd);
        end
    endtask

    task automatic test_edge_irq();
        logic [31:0] rd;
        bus_write(3'd3, 32'hFF);
        bus_write(3'd2, 32'h01);
        pio_in = 8'h31;
        repeat (2) @(negedge clk);
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL edge_too_early cap=%h irq=%b want cap=0 irq=0", rd, irq);
        end
        @(negedge clk);
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h01 || irq !== 1'b1) begin
            errors++;
            $display("FAIL edge_capture cap=%h irq=%b want cap=01 irq=1", rd, irq);
        end
        bus_write(3'd3, 32'h01);
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL edge_clear cap=%h irq=%b want cap=0 irq=0", rd, irq);
        end
    endtask

    task automatic test_set_wins();
        logic [31:0] rd;
        pio_in = 8'h35;
        repeat (2) @(negedge clk);
        bus_write(3'd3, 32'h04);
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h04) begin
            errors++;
            $display("FAIL set_wins cap=%h want=00000004", rd);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL masked_irq irq=%b want=0", irq);
        end
    endtask

    task automatic test_bitsetclr();
        logic [31:0] rd;
        logic [7:0]  exp_set, exp_clr;
`ifdef NIOS_PIO_BITSETCLR_EN
        exp_set = 8'h3F;
        exp_clr = 8'h3C;
`else
        exp_set = 8'h0F;
        exp_clr = 8'h0F;
`endif
        bus_write(3'd0, 32'h0F);
        bus_write(3'd4, 32'h30);
        checks++;
        if (pio_out !== exp_set) begin
            errors++;
            $display("FAIL outset got=%h want=%h", pio_out, exp_set);
        end
        bus_write(3'd5, 32'h03);
        checks++;
        if (pio_out !== exp_clr) begin
            errors++;
            $display("FAIL outclr got=%h want=%h", pio_out, exp_clr);
        end
        for (int a = 4; a < 8; a++) begin
            bus_read(3'(a), rd);
            checks++;
            if (rd !== 32'h0) begin
                errors++;
                $display("FAIL unmapped_read addr=%0d got=%h want=0", a, rd);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        bus_write(3'd2, 32'hFF);
        pio_in = 8'h00;
        repeat (4) @(negedge clk);
        pio_in = 8'hFF;
        repeat (4) @(negedge clk);
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'hFF || irq !== 1'b1) begin
            errors++;
            $display("FAIL pending_before_reset cap=%h irq=%b want cap=ff irq=1", rd, irq);
        end
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = 3'd3;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (readdata !== 32'h0 || irq !== 1'b0 || pio_out !== RV || pio_oe !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid cap=%h irq=%b out=%h oe=%h want cap=0 irq=0 out=%h oe=0",
                     readdata, irq, pio_out, pio_oe, RV);
        end
        chipselect = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL no_spurious_after_reset cap=%h want=0", rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp;
        for (int i = 0; i < 600; i++) begin
            chipselect = ($urandom_range(0, 3) != 0);
            write_n    = ($urandom_range(0, 2) != 0);
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom;
            if ($urandom_range(0, 2) == 0) pio_in = 8'($urandom);
            #1;
            if (chipselect) begin
                exp = exp_read(address);
                checks++;
                if (readdata !== exp) begin
                    errors++;
                    $display("FAIL rand_read i=%0d addr=%0d got=%h want=%h", i, address, readdata, exp);
                end
            end
            checks++;
            if (pio_out !== data_m || pio_oe !== dir_m || irq !== |(cap_m & mask_m)) begin
                errors++;
                $display("FAIL rand_outputs i=%0d out=%h oe=%h irq=%b want out=%h oe=%h irq=%b",
                         i, pio_out, pio_oe, irq, data_m, dir_m, |(cap_m & mask_m));
            end
            @(negedge clk);
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        test_reset();
        test_dir_data();
        test_edge_irq();
        test_set_wins();
        test_bitsetclr();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
